// File: rtl/pci_target_controller.sv
// PCI-style bus target: decodes the address phase, claims hits with devsel and
// serves burst memory reads/writes from an 8x32 word store with byte enables.
module pci_target_controller #(
  parameter logic [1:0]  DEV_ADDR  = 2'b01,
  parameter int unsigned INIT_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] AD,
  input  logic [3:0]  C_BE,
  input  logic        frame,
  input  logic        irdy,
  output logic        trdy,
  output logic        devsel,
  output logic        busy,
  output logic [3:0]  xfer_count,
  output logic [2:0]  dbg_state,
  output logic        dbg_ad_oe
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IGNORE  = 3'd1,
    CLAIM   = 3'd2,
    DATA    = 3'd3,
    TURNOFF = 3'd4
  } state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(INIT_WAIT);

  // Handshake: a data transfer happens on a posedge in DATA with irdy=0 and
  // trdy=0; frame=1 on that edge marks the last one. frame=1 with irdy=1 while
  // claimed is an initiator abort.

  state_t      state;
  logic        frame_q;
  logic        is_write;
  logic [2:0]  ptr;
  logic [1:0]  wait_cnt;
  logic        ad_oe;
  logic [31:0] mem [8];
  logic        hit;

  assign hit = (AD[1:0] == DEV_ADDR) && (AD[31:5] == 27'd0) &&
               (C_BE[3:1] == 3'b011);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame_q    <= 1'b1;
      is_write   <= 1'b0;
      ptr        <= 3'd0;
      wait_cnt   <= 2'd0;
      ad_oe      <= 1'b0;
      trdy       <= 1'b1;
      devsel     <= 1'b1;
      xfer_count <= 4'd0;
      for (int i = 0; i < 8; i++) mem[i] <= 32'd0;
    end else begin
      frame_q <= frame;
      case (state)
        IDLE: begin
          if (!frame && frame_q) begin
            if (hit) begin
              state      <= CLAIM;
              is_write   <= C_BE[0];
              ptr        <= AD[4:2];
              xfer_count <= 4'd0;
              wait_cnt   <= WAIT_LOAD;
            end else begin
              state <= IGNORE;
            end
          end
        end
        IGNORE: begin
          if (frame && irdy) state <= IDLE;
        end
        CLAIM: begin
          if (frame && irdy) begin
            state  <= IDLE;
            devsel <= 1'b1;
            trdy   <= 1'b1;
          end else begin
            devsel <= 1'b0;
            // The first CLAIM edge only asserts devsel; trdy follows INIT_WAIT edges later.
            if (wait_cnt == 2'd0) begin
              state <= DATA;
              trdy  <= 1'b0;
              ad_oe <= !is_write;
            end else begin
              wait_cnt <= wait_cnt - 2'd1;
            end
          end
        end
        DATA: begin
          if (!irdy) begin
            if (is_write) begin
              for (int i = 0; i < 4; i++) begin
                if (!C_BE[i]) mem[ptr][8*i +: 8] <= AD[8*i +: 8];
              end
            end
            ptr <= ptr + 3'd1;
            if (xfer_count != 4'd15) xfer_count <= xfer_count + 4'd1;
            if (frame) begin
              state  <= TURNOFF;
              trdy   <= 1'b1;
              devsel <= 1'b1;
              ad_oe  <= 1'b0;
            end
          end else if (frame) begin
            state  <= IDLE;
            trdy   <= 1'b1;
            devsel <= 1'b1;
            ad_oe  <= 1'b0;
          end
        end
        TURNOFF: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data follows the pointer directly so a transfer edge presents the next word at once.
  assign AD         = ad_oe ? mem[ptr] : 32'bz;
  assign busy       = (state == CLAIM) || (state == DATA);
  assign dbg_state  = state;
  assign dbg_ad_oe  = ad_oe;

endmodule
